// File: rtl/alu_armv4_pkg.sv
// Shared definitions for the ARMv4 ALU path: condition codes, flag bit
// positions, ALU opcodes and the condition evaluation helper.
package alu_armv4_pkg;

    localparam int DEPTH = 2;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // NV is architecturally unpredictable on ARMv4; it is treated as never.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic p;
        p = 1'b0;
        case (cond_e'(cond))
            EQ: p = flags[Z];
            NE: p = !flags[Z];
            CS: p = flags[C];
            CC: p = !flags[C];
            MI: p = flags[N];
            PL: p = !flags[N];
            VS: p = flags[V];
            VC: p = !flags[V];
            HI: p = flags[C] & !flags[Z];
            LS: p = !flags[C] | flags[Z];
            GE: p = (flags[N] == flags[V]);
            LT: p = (flags[N] != flags[V]);
            GT: p = !flags[Z] & (flags[N] == flags[V]);
            LE: p = flags[Z] | (flags[N] != flags[V]);
            AL: p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alu_cond_wb_stage_if.sv
// Bundle between the ALU, the condition/writeback stage and the register file.
interface alu_cond_wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out;
    logic        nf;
    logic        zf;
    logic        cf;
    logic        vf;
    logic [3:0]  cond;
    logic        s_bit;
    logic        wb_en;
    logic [3:0]  rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic [3:0]  flags;
    logic [7:0]  skip_cnt;

    modport master (
        output in_valid, out, nf, zf, cf, vf, cond, s_bit, wb_en, rd, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd, flags, skip_cnt
    );

    modport slave (
        input  in_valid, out, nf, zf, cf, vf, cond, s_bit, wb_en, rd, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd, flags, skip_cnt
    );
endinterface

// File: rtl/alu_cond_wb_stage_fifo2.sv
// Two-entry {rd, data} writeback buffer with a registered head that reads
// as zero whenever the buffer is empty.
module alu_wb_fifo2
    import alu_armv4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [3:0]  push_rd,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [3:0]  head_rd,
    output logic [31:0] head_data
);

    logic [35:0] mem [DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == 2'd0);
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_rd, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            // Push and pop together leave occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign {head_rd, head_data} = empty ? 36'd0 : mem[rd_ptr];

endmodule

// File: rtl/alu_cond_wb_stage.sv
// Condition-evaluation and writeback stage: holds the architectural NZCV
// register and skip counter, and queues passing writebacks to the register file.
module alu_cond_wb_stage
    import alu_armv4_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_cond_wb_stage_if.slave  bus
);

    logic [3:0] flags_q;
    logic [7:0] skip_q;
    logic       full;
    logic       empty;
    logic       pass;
    logic       accept;
    logic       push;
    logic       pop;

    // Condition uses the committed flags so a dependent instruction one cycle
    // later sees exactly what the previous one wrote.
    assign pass   = cond_pass(bus.cond, flags_q);
    assign accept = bus.in_valid & !full;
    assign push   = accept & pass & bus.wb_en;
    assign pop    = !empty & bus.wb_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
            skip_q  <= 8'd0;
        end else if (accept) begin
            if (!pass)
                skip_q <= skip_q + 8'd1;
            else if (bus.s_bit)
                flags_q <= {bus.nf, bus.zf, bus.cf, bus.vf};
        end
    end

    alu_wb_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (bus.rd),
        .push_data (bus.out),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head_rd   (bus.wb_rd),
        .head_data (bus.wb_data)
    );

    assign bus.in_ready = !full;
    assign bus.wb_valid = !empty;
    assign bus.flags    = flags_q;
    assign bus.skip_cnt = skip_q;

endmodule

// File: tb/tb_alu_cond_wb_stage.sv
// Bench for alu_cond_wb_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_cond_wb_stage;

    logic clk;
    logic rst;
    alu_cond_wb_stage_if bus ();

    alu_cond_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit [3:0]  mFlags;
    bit [7:0]  mSkip;
    bit [35:0] mQ[$];

    // Conditions come in complementary pairs; odd codes invert the even rule.
    function automatic bit modelPass(input int cond, input bit [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (cond % 2 == 1) ? !base : base;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        bit [35:0] head;
        head = (mQ.size() > 0) ? mQ[0] : 36'd0;
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mQ.size() < 2));
        checkOutput({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(mQ.size() > 0));
        checkOutput({tag, ".wb_rd"},    32'(bus.wb_rd),    32'(head[35:32]));
        checkOutput({tag, ".wb_data"},  bus.wb_data,       head[31:0]);
        checkOutput({tag, ".flags"},    32'(bus.flags),    32'(mFlags));
        checkOutput({tag, ".skip_cnt"}, 32'(bus.skip_cnt), 32'(mSkip));
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model over the edge.
    task automatic applyStimulus(input string tag, input bit v, input bit [31:0] d, input bit [3:0] nzcv,
                                 input bit [3:0] c, input bit s, input bit we, input bit [3:0] r,
                                 input bit rdy, output bit taken);
        bit accepted, popped;
        bus.in_valid = v;
        bus.out      = d;
        {bus.nf, bus.zf, bus.cf, bus.vf} = nzcv;
        bus.cond     = c;
        bus.s_bit    = s;
        bus.wb_en    = we;
        bus.rd       = r;
        bus.wb_ready = rdy;
        @(negedge clk);
        checkAll(tag);
        @(posedge clk);
        accepted = v && (mQ.size() < 2);
        popped   = rdy && (mQ.size() > 0);
        if (popped) void'(mQ.pop_front());
        if (accepted) begin
            if (modelPass(int'(c), mFlags)) begin
                if (s) mFlags = nzcv;
                if (we) mQ.push_back({r, d});
            end else begin
                mSkip = mSkip + 8'd1;
            end
        end
        taken = accepted;
        #1;
    endtask

    task automatic idle(input string tag, input bit rdy, input int n);
        bit t;
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 4'hE, 0, 0, 0, rdy, t);
    endtask

    initial begin
        bit t;
        bit hold;
        bit v;
        bit rdy;
        bit [31:0] d;
        bit [3:0] nzcv, c, r;
        bit s, we;
        int k;

        rst = 1'b1;
        bus.in_valid = 0; bus.out = 0; bus.nf = 0; bus.zf = 0; bus.cf = 0; bus.vf = 0;
        bus.cond = 0; bus.s_bit = 0; bus.wb_en = 0; bus.rd = 0; bus.wb_ready = 0;
        mFlags = 0; mSkip = 0; mQ.delete();
        #3;
        checkAll("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // ADD 0x7FFFFFFF + 1 result, flags N and V set.
        applyStimulus("add_ovf", 1, 32'h8000_0000, 4'b1001, 4'hE, 1, 1, 4'd3, 0, t);
        idle("add_ovf_wait", 0, 1);
        checkOutput("add_ovf.flags_abs", 32'(bus.flags), 32'h9);
        checkOutput("add_ovf.wb_data_abs", bus.wb_data, 32'h8000_0000);
        idle("add_ovf_drain", 1, 2);

        // With Z set: NE is skipped, EQ pushes without touching the flags.
        applyStimulus("setz", 1, 32'h0, 4'b0100, 4'hE, 1, 0, 4'd0, 1, t);
        applyStimulus("ne_skip", 1, 32'h1111, 4'b0000, 4'h1, 0, 1, 4'd5, 1, t);
        applyStimulus("eq_pass", 1, 32'h2222, 4'b0000, 4'h0, 0, 1, 4'd6, 1, t);
        idle("eq_drain", 1, 2);

        // Dependent pair: clear Z first, then SUB 5-5 sets Z, EQ immediately follows.
        applyStimulus("clrz", 1, 32'h1, 4'b0000, 4'hE, 1, 0, 4'd0, 1, t);
        applyStimulus("sub55", 1, 32'h0, 4'b0110, 4'hE, 1, 1, 4'd1, 1, t);
        applyStimulus("dep_eq", 1, 32'h7, 4'b0000, 4'h0, 0, 1, 4'd2, 1, t);
        idle("dep_drain", 1, 3);

        // Stall: three writebacks against a blocked register file, then drain.
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            v = (k < 3);
            applyStimulus("stall", v, 32'hA000_0000 + 32'(k), 4'b0000, 4'hE, 0, 1, 4'(8 + k), cyc >= 4, t);
            if (t) k++;
        end
        checkOutput("stall.all_accepted", 32'(k), 32'd3);

        // NV never passes, even with S set; then 256 more failures wrap the counter.
        applyStimulus("nv_s", 1, 32'h5, 4'b1111, 4'hF, 1, 1, 4'd4, 1, t);
        for (int i = 0; i < 256; i++)
            applyStimulus("nv_wrap", 1, 32'(i), 4'(i), 4'hF, 1, 1, 4'(i), 1, t);
        idle("nv_after", 1, 1);

        // Random traffic; an unaccepted instruction is held by the upstream.
        hold = 0; v = 0; d = 0; nzcv = 0; c = 0; s = 0; we = 0; r = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                v    = ($urandom_range(0, 3) != 0);
                d    = $urandom;
                nzcv = 4'($urandom);
                c    = 4'($urandom);
                s    = 1'($urandom);
                we   = ($urandom_range(0, 3) != 0);
                r    = 4'($urandom);
            end
            rdy = ($urandom_range(0, 2) != 0);
            applyStimulus("rand", v, d, nzcv, c, s, we, r, rdy, t);
            hold = v && !t;
        end
        idle("rand_drain", 1, 3);

        // Asynchronous reset with two entries buffered and all flags set.
        applyStimulus("prerst_a", 1, 32'hDEAD_0001, 4'b1111, 4'hE, 1, 1, 4'd11, 0, t);
        applyStimulus("prerst_b", 1, 32'hDEAD_0002, 4'b1111, 4'hE, 0, 1, 4'd12, 0, t);
        applyStimulus("prerst_nv", 1, 32'h0, 4'b0000, 4'hF, 0, 0, 4'd0, 0, t);
        bus.in_valid = 0;
        rst = 1'b1;
        #2;
        mFlags = 0; mSkip = 0; mQ.delete();
        checkAll("async_rst");
        #1 rst = 1'b0;
        idle("post_rst", 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cond_wb_stage.md
# alu_cond_wb_stage

Downstream stage of the ARMv4 ALU (ADD/SUB/AND/OR with NZCV flags). Each cycle it can accept one ALU result with its instruction tag. It evaluates the ARM condition field against the architectural NZCV register, commits flags when the S bit is set, and queues register writebacks in a 2-entry buffer. The buffer drains to the register file over a valid/ready handshake.

## Interface
- DEPTH, 2, writeback buffer entries (fixed at 2; pointer widths derive from it)
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  ALU result and tag valid this cycle
- IN_READY  output  1  stage can accept (buffer not full)
- OUT  input  32  ALU result
- NF, ZF, CF, VF  input  1 each  ALU flags for this result
- COND  input  4  ARM condition field of the instruction
- S_BIT  input  1  instruction updates flags
- WB_EN  input  1  instruction writes a destination (0 for CMP/TST-type)
- RD  input  4  destination register index
- WB_VALID  output  1  buffer head valid
- WB_READY  input  1  register file accepts head
- WB_DATA  output  32  head result
- WB_RD  output  4  head destination
- FLAGS  output  4  architectural {N,Z,C,V}
- SKIP_CNT  output  8  count of accepted instructions whose condition failed, wraps at 255→0

## Operation
- Accept = IN_VALID & IN_READY. IN_READY = !full; it is combinational from buffer state only and never depends on WB_READY.
- Condition pass is computed from registered FLAGS (pre-update), never from the incoming NF..VF.
  - EQ 0:Z; NE 1:!Z; CS 2:C; CC 3:!C; MI 4:N; PL 5:!N; VS 6:V; VC 7:!V
  - HI 8:C&!Z; LS 9:!C|Z; GE A:N==V; LT B:N!=V; GT C:!Z&(N==V); LE D:Z|(N!=V)
  - AL E:1; F:0 (NV is treated as never)
- On accept with pass:
  - if S_BIT, FLAGS <= {NF,ZF,CF,VF};
  - if WB_EN, push {RD,OUT} into the buffer.
- On accept with fail: no flag change, no push, SKIP_CNT increments.
- Accept with pass, S_BIT=0, WB_EN=0 is a legal no-op and is still consumed.
- Pop = WB_VALID & WB_READY. Head advances and the next entry is presented in the next cycle.
- Simultaneous push and pop:
  - when 1 entry is held, occupancy stays 1 and the new entry becomes head after the pop;
  - when full, IN_READY=0, so no push occurs.
- WB_DATA/WB_RD hold stable while WB_VALID=1 and WB_READY=0. They are don't-care when WB_VALID=0 but are driven to 0 in this state.
- IN_VALID while IN_READY=0: the instruction is not consumed and has no side effects. The upstream holds it.

## Timing
- Reset (asynchronous, active-high): FLAGS=4'b0000, SKIP_CNT=0, buffer empty, WB_VALID=0, WB_DATA=0, WB_RD=0, IN_READY=1 while RST is deasserted.
- Reset mid-operation discards buffered writebacks immediately; outputs take their reset values without waiting for a clock edge.
- Latency:
  - accepted writeback appears on WB_VALID in the cycle after the accept edge;
  - FLAGS update is visible in the cycle after the accept edge.
- Back-to-back dependent instructions are handled correctly. Instruction i+1 accepted the next cycle sees flags written by instruction i.
- Sustained throughput is one instruction per cycle while WB_READY=1.
- Full condition (2 entries): IN_READY falls in the cycle after the second push. It rises in the cycle after a pop.
- Pointers are 1-bit read/write plus a 2-bit count; wrap-around is natural. Count never exceeds 2.

## Structure
- Shared package alu_armv4_pkg:
  - cond_e enum (EQ..NV, 4 bits);
  - flag index constants N=3, Z=2, C=1, V=0;
  - function cond_pass(cond, flags) returning 1 bit.
- Alu_armv4_pkg also holds the ALU_C encoding constants (ADD=00, SUB=01, AND=10, OR=11) for the whole ALU path.
- Sub-module alu_wb_fifo2: the 2-entry {RD,DATA} buffer with push/pop, full/empty and registered head.
- Top level holds the FLAGS register, SKIP_CNT and accept logic.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 results (OUT=0x80000000, NF=1, VF=1), COND=E, S_BIT=1, WB_EN=1, RD=3 → next cycle FLAGS=4'b1001, WB_VALID=1, WB_RD=3, WB_DATA=0x80000000.
- FLAGS=Z set. Send COND=1 (NE) with WB_EN=1, then COND=0 (EQ) → first is skipped (SKIP_CNT=1, no push); second pushes and FLAGS are unchanged when S_BIT=0.
- Dependent pair: SUB 5-5 (ZF=1, S_BIT=1) then COND=0 next cycle → second passes using the new Z, and one writeback follows each.
- WB_READY=0 for 4 cycles while issuing 3 instructions → two pushed, IN_READY=0 from cycle 3, third held. WB_READY=1 → pops 2, then the third, in order with data stable while stalled.
- COND=F with S_BIT=1 → FLAGS unchanged, SKIP_CNT increments. Issue 256 failing instructions → SKIP_CNT wraps to 0.
- Assert RST with 2 entries buffered and FLAGS=4'b1111 → WB_VALID=0, FLAGS=0, SKIP_CNT=0 without a clock edge; IN_READY=1 after release.
